// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
// Definitions shared by the matrix coprocessor datapath (loader, determinant
// and arithmetic stages).
//   DIM      : physical row stride and largest supported matrix dimension
//   ELEM_W   : element width, signed two's complement
//   FLAT_W   : width of the flattened DIM x DIM image
//   SIZE_W   : width of a matrix-dimension field
//   SIZE_MIN / SIZE_MAX : legal range of square dimensions
//   state_t  : loader FSM states
//   elem_lsb : bit offset of element (row,col) inside the flat image
//   size_legal : true when a requested dimension lies in SIZE_MIN..SIZE_MAX
// ---------------------------------------------------------------------------
package matrix_pkg;

   localparam int DIM      = 5;
   localparam int ELEM_W   = 8;
   localparam int FLAT_W   = DIM * DIM * ELEM_W;
   localparam int SIZE_W   = 3;
   localparam int SIZE_MIN = 2;
   localparam int SIZE_MAX = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   // Row-major layout with a fixed stride of DIM, independent of the loaded N.
   function automatic int elem_lsb(input int row, input int col);
      return (row * DIM + col) * ELEM_W;
   endfunction

   function automatic logic size_legal(input logic [SIZE_W-1:0] n);
      return (int'(n) >= SIZE_MIN) && (int'(n) <= SIZE_MAX);
   endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// ---------------------------------------------------------------------------
// matrix_loader_if
// Bundles the control, element stream and image signals of matrix_loader.
//   start, size      : load request and requested dimension N
//   in_valid/in_data : element stream (row-major), in_ready back-pressure
//   consume          : downstream acknowledgement of a finished image
//   A_flat, size_q   : finished image and its dimension
//   matrix_valid     : image complete and stable
//   busy             : a load is in progress or an image is held
//   size_err         : one-cycle pulse for an illegal requested size
// Modports:
//   master : the producer/consumer side that drives requests and elements
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface matrix_loader_if;
   import matrix_pkg::*;

   logic                start;
   logic [SIZE_W-1:0]   size;
   logic                in_valid;
   logic [ELEM_W-1:0]   in_data;
   logic                in_ready;
   logic                consume;
   logic [FLAT_W-1:0]   A_flat;
   logic [SIZE_W-1:0]   size_q;
   logic                matrix_valid;
   logic                busy;
   logic                size_err;

   modport master (
      output start, size, in_valid, in_data, consume,
      input  in_ready, A_flat, size_q, matrix_valid, busy, size_err
   );

   modport slave (
      input  start, size, in_valid, in_data, consume,
      output in_ready, A_flat, size_q, matrix_valid, busy, size_err
   );

endinterface

// File: rtl/matrix_loader.sv
// ---------------------------------------------------------------------------
// matrix_loader
// Collects signed elements one per beat from a valid/ready stream and places
// them row-major into the DIM x DIM flat image used by the determinant and
// arithmetic stages. The finished image is held with matrix_valid until the
// consumer acknowledges it. Square sizes SIZE_MIN..SIZE_MAX are supported;
// positions outside the loaded N x N block read as zero.
// Ports:
//   clock : single clock, all state updates on its rising edge
//   reset : synchronous, active-high; aborts any load in progress
//   bus   : matrix_loader_if.slave (request, element stream, image outputs)
// Layout and geometry (DIM, ELEM_W) come from matrix_pkg so every stage of
// the datapath agrees on where element (r,c) lives.
// ---------------------------------------------------------------------------
module matrix_loader
   import matrix_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   matrix_loader_if.slave  bus
);

   state_t              state_reg, state_next;
   logic [SIZE_W-1:0]   row_reg, row_next;
   logic [SIZE_W-1:0]   col_reg, col_next;
   logic [SIZE_W-1:0]   size_q_reg, size_q_next;
   logic [FLAT_W-1:0]   a_flat_reg, a_flat_next;
   logic                size_err_reg, size_err_next;
   logic                matrix_valid_reg, matrix_valid_next;
   logic                busy_reg, busy_next;

   logic                load_clear;   // legal start: wipe the whole image
   logic                accept;       // element handshake this cycle
   logic                last_col;
   logic                last_row;

   assign last_col = (col_reg == size_q_reg - 3'd1);
   assign last_row = (row_reg == size_q_reg - 3'd1);

   // -----------------------------------------------------------------------
   // Next-state and control decode
   // -----------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      row_next      = row_reg;
      col_next      = col_reg;
      size_q_next   = size_q_reg;
      size_err_next = 1'b0;
      load_clear    = 1'b0;
      accept        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               if (size_legal(bus.size)) begin
                  load_clear  = 1'b1;
                  size_q_next = bus.size;
                  row_next    = '0;
                  col_next    = '0;
                  state_next  = LOAD;
               end else begin
                  // Image and latched size are left untouched on an error.
                  size_err_next = 1'b1;
               end
            end
         end

         LOAD: begin
            if (bus.in_valid) begin
               accept = 1'b1;
               if (last_col) begin
                  col_next = '0;
                  row_next = row_reg + 3'd1;
                  if (last_row) begin
                     state_next = FULL;
                  end
               end else begin
                  col_next = col_reg + 3'd1;
               end
            end
         end

         FULL: begin
            // start is deliberately ignored here, even alongside consume.
            if (bus.consume) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      matrix_valid_next = (state_next == FULL);
      busy_next         = (state_next != IDLE);
   end

   // -----------------------------------------------------------------------
   // Element write decoder: one comparator and mux per image position.
   // Positions with row or col >= N are never addressed by the counters, so
   // they keep the zero written at load start.
   // -----------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < DIM * DIM; gi++) begin : g_elem
         localparam int ROW = gi / DIM;
         localparam int COL = gi % DIM;
         localparam int LSB = elem_lsb(ROW, COL);

         logic elem_we;

         assign elem_we = accept
                          && (row_reg == SIZE_W'(ROW))
                          && (col_reg == SIZE_W'(COL));

         assign a_flat_next[LSB +: ELEM_W] =
            load_clear ? '0 :
            elem_we    ? bus.in_data :
                         a_flat_reg[LSB +: ELEM_W];
      end
   endgenerate

   // -----------------------------------------------------------------------
   // State and output registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= IDLE;
         row_reg          <= '0;
         col_reg          <= '0;
         size_q_reg       <= '0;
         a_flat_reg       <= '0;
         size_err_reg     <= 1'b0;
         matrix_valid_reg <= 1'b0;
         busy_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         row_reg          <= row_next;
         col_reg          <= col_next;
         size_q_reg       <= size_q_next;
         a_flat_reg       <= a_flat_next;
         size_err_reg     <= size_err_next;
         matrix_valid_reg <= matrix_valid_next;
         busy_reg         <= busy_next;
      end
   end

   // in_ready is the only output decoded straight from state.
   assign bus.in_ready     = (state_reg == LOAD);
   assign bus.A_flat       = a_flat_reg;
   assign bus.size_q       = size_q_reg;
   assign bus.matrix_valid = matrix_valid_reg;
   assign bus.busy         = busy_reg;
   assign bus.size_err     = size_err_reg;

endmodule
